pifo_deq_ctrl: RTL and testbench
================================

Name: pifo_deq_ctrl

Overview:
- Dequeue controller sitting directly downstream of the PIFO register block.
- Watches the PIFO's min-entry outputs and issues single-cycle remove pulses.
- Captures each removed {rank, meta} into a small output FIFO.
- Presents entries to the downstream scheduler/output queue over a valid/ready interface, respecting the PIFO's min/max recompute latency so no stale minimum is ever popped.

Parameters:
- RANK_WIDTH, 8, width of rank field.
- META_WIDTH, 8, width of metadata field.
- L2_OBUF_DEPTH, 1, log2 of output FIFO depth (default 2 entries).
- HOLDOFF, 2, cycles remove is suppressed after a pop while the PIFO recomputes min (minimum legal 2).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- deq_en  in  1  dequeue enable; low blocks new removes.
- pifo_rank  in  RANK_WIDTH  PIFO current min rank.
- pifo_meta  in  META_WIDTH  PIFO meta of min entry.
- pifo_valid  in  1  PIFO min outputs valid.
- pifo_empty  in  1  PIFO empty flag.
- pifo_remove  out  1  one-cycle remove pulse to PIFO.
- m_rank  out  RANK_WIDTH  head-of-FIFO rank.
- m_meta  out  META_WIDTH  head-of-FIFO meta.
- m_valid  out  1  output FIFO non-empty.
- m_ready  in  1  downstream accepts head.
- obuf_count  out  L2_OBUF_DEPTH+1  output FIFO occupancy.

Behaviour:
- Reset: rst is synchronous, active-high; clock is clk. On reset:
  - pifo_remove=0, m_valid=0, m_rank=0, m_meta=0, obuf_count=0.
  - FSM enters IDLE; holdoff counter 0; FIFO read/write pointers 0.
  - Reset mid-holdoff aborts the holdoff; any FIFO contents are discarded.
- FSM states: IDLE, HOLD.
- IDLE to HOLD occurs when deq_en=1, pifo_valid=1, pifo_empty=0 and obuf_count < 2**L2_OBUF_DEPTH. In that same cycle:
  - pifo_remove is driven 1 combinationally from the registered state and qualifiers.
  - pifo_rank/pifo_meta are written into the FIFO at the clock edge.
  - The holdoff counter is loaded with HOLDOFF-1.
- HOLD:
  - pifo_remove=0.
  - Counter decrements each cycle; at 0 the FSM returns to IDLE.
  - pifo_valid is ignored in HOLD, because it is stale for one cycle after remove.
- Pop rate: maximum one pop per HOLDOFF+1 cycles. pifo_remove is never high two consecutive cycles.
- If deq_en drops during HOLD, the holdoff still completes; no new remove issues until deq_en=1.
- Output FIFO:
  - Registered storage; m_valid = (obuf_count != 0).
  - m_rank/m_meta show the head entry; they are 0 when the FIFO is empty.
  - Pop on m_valid & m_ready.
  - A simultaneous write and pop leaves obuf_count unchanged; pointers wrap modulo depth.
- Latency: from the remove cycle to m_valid=1 at an empty FIFO is 1 clock.
- Full FIFO: no remove issues; the PIFO min is untouched until space frees. The remove condition uses the registered obuf_count, so a pop in the same cycle does not enable a remove.
- pifo_empty=1 with pifo_valid=1 (transient): treated as not valid; no remove.
- Upstream insert in the same cycle as remove: no special handling. The PIFO prioritises remove and latches the insert.
- m_ready held high with a full stream: FIFO occupancy stays ≤1.

Optional Feature:
- Macro: PIFO_DEQ_STATS_EN.
- Defined: adds outputs deq_count[31:0] and stall_count[31:0].
  - deq_count increments on every pifo_remove.
  - stall_count increments on every cycle with m_valid=1 and m_ready=0.
  - Both counters saturate at 32'hFFFFFFFF and reset to 0 on rst.
- Undefined: neither port nor counter logic exists; all other behaviour is identical.

Test Plan:
- Basic pop:
  - Stimulus: reset, then pifo_valid=1, rank=8'h05, meta=8'hA1, deq_en=1, m_ready=1.
  - Response: pifo_remove high exactly one cycle; next cycle m_valid=1 with m_rank=05, m_meta=A1; no further remove for 2 cycles.
- Backpressure:
  - Stimulus: m_ready=0, PIFO continuously valid with ranks 1,2,3.
  - Response: exactly 2 removes; obuf_count=2, then no remove while full.
  - Then raise m_ready for one cycle: one pop of rank 1, and the next remove follows in the following IDLE cycle.
- Stale-valid guard:
  - Stimulus: hold pifo_valid=1 constantly with HOLDOFF=2.
  - Response: removes spaced exactly 3 cycles apart; never in consecutive cycles.
- Enable and empty:
  - Stimulus: deq_en=0 with pifo_valid=1 → response: no remove.
  - Stimulus: deq_en=1 with pifo_empty=1, pifo_valid=1 → response: no remove.
- Reset mid-operation:
  - Stimulus: assert rst during HOLD with obuf_count=1.
  - Response: next cycle m_valid=0, obuf_count=0, pifo_remove=0; a remove is possible on the first valid cycle after rst deasserts.
- Stats (macro defined):
  - Stimulus: 5 pops, then 7 cycles with m_valid=1 and m_ready=0.
  - Response: deq_count=5, stall_count=7.

Source files
------------

// File: rtl/pifo_deq_ctrl.sv
// pifo_deq_ctrl: dequeue controller downstream of the PIFO register block.
// Issues one-cycle remove pulses when the PIFO min is valid, captures the
// removed {rank, meta} into a small output FIFO and presents the FIFO head on
// a valid/ready interface. After each remove the PIFO needs HOLDOFF cycles to
// recompute its min, so new removes are suppressed for that long.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   deq_en              dequeue enable (low blocks new removes)
//   pifo_rank/meta      PIFO min entry
//   pifo_valid/empty    PIFO min valid / PIFO empty
//   pifo_remove         one-cycle remove pulse to the PIFO
//   m_rank/m_meta       FIFO head (0 when empty)
//   m_valid/m_ready     downstream handshake
//   obuf_count          FIFO occupancy
//   deq_count/stall_count  statistics, only with PIFO_DEQ_STATS_EN defined
//
// Optional feature macro: PIFO_DEQ_STATS_EN
module pifo_deq_ctrl #(
  parameter int RANK_WIDTH    = 8,
  parameter int META_WIDTH    = 8,
  parameter int L2_OBUF_DEPTH = 1,
  parameter int HOLDOFF       = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     deq_en,
  input  logic [RANK_WIDTH-1:0]    pifo_rank,
  input  logic [META_WIDTH-1:0]    pifo_meta,
  input  logic                     pifo_valid,
  input  logic                     pifo_empty,
  output logic                     pifo_remove,
  output logic [RANK_WIDTH-1:0]    m_rank,
  output logic [META_WIDTH-1:0]    m_meta,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [L2_OBUF_DEPTH:0]   obuf_count
`ifdef PIFO_DEQ_STATS_EN
  ,
  output logic [31:0]              deq_count,
  output logic [31:0]              stall_count
`endif
);

  localparam int DEPTH = 2 ** L2_OBUF_DEPTH;
  localparam int CW    = $clog2(HOLDOFF + 1);
  localparam int EW    = RANK_WIDTH + META_WIDTH;
  localparam logic [L2_OBUF_DEPTH:0] DEPTH_C  = (L2_OBUF_DEPTH + 1)'(DEPTH);
  localparam logic [CW-1:0]          HOLD_LD  = CW'(HOLDOFF - 1);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t                   state_q, state_d;
  logic [CW-1:0]            hcnt_q, hcnt_d;
  logic                     can_rm;
  logic                     pop;

  logic [EW-1:0]            mem [DEPTH];
  logic [L2_OBUF_DEPTH-1:0] wr_ptr, rd_ptr;

  // Full check uses the registered count: a same-cycle pop never frees space
  // for a remove. pifo_empty overrides a transient pifo_valid.
  assign can_rm = !rst && deq_en && pifo_valid && !pifo_empty && (obuf_count < DEPTH_C);
  assign pop    = m_valid && m_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      hcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      hcnt_q  <= hcnt_d;
    end
  end

  // pifo_valid is not looked at in HOLD: it is stale right after a remove.
  always_comb begin
    state_d     = state_q;
    hcnt_d      = hcnt_q;
    pifo_remove = 1'b0;
    case (state_q)
      IDLE: begin
        if (can_rm) begin
          pifo_remove = 1'b1;
          state_d     = HOLD;
          hcnt_d      = HOLD_LD;
        end
      end
      HOLD: begin
        if (hcnt_q == '0) state_d = IDLE;
        else              hcnt_d  = hcnt_q - 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output FIFO; pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      obuf_count <= '0;
    end else begin
      if (pifo_remove) begin
        mem[wr_ptr] <= {pifo_rank, pifo_meta};
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({pifo_remove, pop})
        2'b10:   obuf_count <= obuf_count + 1'b1;
        2'b01:   obuf_count <= obuf_count - 1'b1;
        default: obuf_count <= obuf_count;
      endcase
    end
  end

  assign m_valid = (obuf_count != '0);
  assign {m_rank, m_meta} = m_valid ? mem[rd_ptr] : '0;

`ifdef PIFO_DEQ_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      deq_count   <= '0;
      stall_count <= '0;
    end else begin
      if (pifo_remove && deq_count != 32'hFFFF_FFFF)
        deq_count <= deq_count + 1'b1;
      if (m_valid && !m_ready && stall_count != 32'hFFFF_FFFF)
        stall_count <= stall_count + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_pifo_deq_ctrl.sv
module tb_pifo_deq_ctrl;
  logic       clk = 1'b0;
  logic       rst, deq_en, pifo_valid, pifo_empty, pifo_remove;
  logic [7:0] pifo_rank, pifo_meta, m_rank, m_meta;
  logic       m_valid, m_ready;
  logic [1:0] obuf_count;
`ifdef PIFO_DEQ_STATS_EN
  logic [31:0] deq_count, stall_count;
`endif

  always #5 clk = ~clk;

  pifo_deq_ctrl dut (
    .clk(clk), .rst(rst), .deq_en(deq_en),
    .pifo_rank(pifo_rank), .pifo_meta(pifo_meta),
    .pifo_valid(pifo_valid), .pifo_empty(pifo_empty),
    .pifo_remove(pifo_remove),
    .m_rank(m_rank), .m_meta(m_meta), .m_valid(m_valid), .m_ready(m_ready),
    .obuf_count(obuf_count)
`ifdef PIFO_DEQ_STATS_EN
    , .deq_count(deq_count), .stall_count(stall_count)
`endif
  );

  typedef struct {
    logic       rst, en, pv, pe;
    logic [7:0] rk, mt;
    logic       rdy;
    logic       rem, mv;
    logic [1:0] cnt;
    logic [7:0] hr;
  } vec_t;

  vec_t        tbl [22];
  logic [15:0] sb_q [$];
  logic [15:0] exp_e;
  logic        prev_rem = 1'b0;
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Sample just before the active edge; scoreboard pushes what was driven
  // at each remove and compares it when the FIFO hands the entry out.
  task automatic settle();
    @(negedge clk);
    if (rst) begin
      sb_q.delete();
    end else begin
      if (pifo_remove) begin
        chk("remove_not_back_to_back", {31'd0, prev_rem}, 32'd0);
        sb_q.push_back({pifo_rank, pifo_meta});
      end
      if (m_valid && m_ready) begin
        if (sb_q.size() == 0) begin
          chk("pop_with_empty_scoreboard", 32'd1, 32'd0);
        end else begin
          exp_e = sb_q.pop_front();
          chk("head_entry", {16'd0, m_rank, m_meta}, {16'd0, exp_e});
        end
      end
    end
    prev_rem = pifo_remove;
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input vec_t v);
    rst = v.rst; deq_en = v.en; pifo_valid = v.pv; pifo_empty = v.pe;
    pifo_rank = v.rk; pifo_meta = v.mt; m_ready = v.rdy;
  endtask

  initial begin
    int nrem;
    int guard;
    // rst en pv pe rank meta rdy | remove m_valid count head_rank
    tbl[0]  = '{1'b1,1'b0,1'b0,1'b0,8'h00,8'h00,1'b0, 1'b0,1'b0,2'd0,8'h00};
    tbl[1]  = '{1'b0,1'b1,1'b1,1'b0,8'h05,8'hA1,1'b1, 1'b1,1'b0,2'd0,8'h00};
    tbl[2]  = '{1'b0,1'b1,1'b1,1'b0,8'h05,8'hA1,1'b1, 1'b0,1'b1,2'd1,8'h05};
    tbl[3]  = '{1'b0,1'b1,1'b1,1'b0,8'h05,8'hA1,1'b1, 1'b0,1'b0,2'd0,8'h00};
    tbl[4]  = '{1'b0,1'b1,1'b1,1'b0,8'h05,8'hA1,1'b1, 1'b1,1'b0,2'd0,8'h00};
    tbl[5]  = '{1'b0,1'b1,1'b1,1'b0,8'h05,8'hA1,1'b1, 1'b0,1'b1,2'd1,8'h05};
    tbl[6]  = '{1'b0,1'b1,1'b1,1'b0,8'h05,8'hA1,1'b1, 1'b0,1'b0,2'd0,8'h00};
    tbl[7]  = '{1'b0,1'b0,1'b1,1'b0,8'h05,8'hA1,1'b1, 1'b0,1'b0,2'd0,8'h00};
    tbl[8]  = '{1'b0,1'b0,1'b1,1'b0,8'h05,8'hA1,1'b1, 1'b0,1'b0,2'd0,8'h00};
    tbl[9]  = '{1'b0,1'b1,1'b1,1'b1,8'h05,8'hA1,1'b1, 1'b0,1'b0,2'd0,8'h00};
    tbl[10] = '{1'b0,1'b1,1'b0,1'b0,8'h05,8'hA1,1'b1, 1'b0,1'b0,2'd0,8'h00};
    tbl[11] = '{1'b0,1'b1,1'b1,1'b0,8'h07,8'h33,1'b0, 1'b1,1'b0,2'd0,8'h00};
    tbl[12] = '{1'b0,1'b1,1'b1,1'b0,8'h08,8'h44,1'b0, 1'b0,1'b1,2'd1,8'h07};
    tbl[13] = '{1'b0,1'b1,1'b1,1'b0,8'h08,8'h44,1'b0, 1'b0,1'b1,2'd1,8'h07};
    tbl[14] = '{1'b0,1'b1,1'b1,1'b0,8'h08,8'h44,1'b0, 1'b1,1'b1,2'd1,8'h07};
    tbl[15] = '{1'b0,1'b1,1'b1,1'b0,8'h09,8'h55,1'b0, 1'b0,1'b1,2'd2,8'h07};
    tbl[16] = '{1'b0,1'b1,1'b1,1'b0,8'h09,8'h55,1'b0, 1'b0,1'b1,2'd2,8'h07};
    tbl[17] = '{1'b0,1'b1,1'b1,1'b0,8'h09,8'h55,1'b0, 1'b0,1'b1,2'd2,8'h07};
    tbl[18] = '{1'b0,1'b1,1'b1,1'b0,8'h09,8'h55,1'b0, 1'b0,1'b1,2'd2,8'h07};
    tbl[19] = '{1'b0,1'b1,1'b1,1'b0,8'h09,8'h55,1'b1, 1'b0,1'b1,2'd2,8'h07};
    tbl[20] = '{1'b0,1'b1,1'b1,1'b0,8'h09,8'h55,1'b0, 1'b1,1'b1,2'd1,8'h08};
    tbl[21] = '{1'b0,1'b1,1'b1,1'b0,8'h09,8'h55,1'b0, 1'b0,1'b1,2'd2,8'h08};

    drive(tbl[0]);
    repeat (2) adv();

    for (int i = 0; i < 22; i++) begin
      drive(tbl[i]);
      settle();
      chk($sformatf("row%0d_remove", i),  {31'd0, pifo_remove}, {31'd0, tbl[i].rem});
      chk($sformatf("row%0d_m_valid", i), {31'd0, m_valid},     {31'd0, tbl[i].mv});
      chk($sformatf("row%0d_count", i),   {30'd0, obuf_count},  {30'd0, tbl[i].cnt});
      chk($sformatf("row%0d_m_rank", i),  {24'd0, m_rank},      {24'd0, tbl[i].hr});
      adv();
    end

    // Reset in the middle of a holdoff with one entry buffered.
    rst = 1'b1; deq_en = 1'b0; m_ready = 1'b0;
    settle(); adv(); settle(); adv();
    rst = 1'b0; deq_en = 1'b1; pifo_valid = 1'b1; pifo_empty = 1'b0;
    pifo_rank = 8'h11; pifo_meta = 8'h22;
    settle(); chk("rstseq_first_remove", {31'd0, pifo_remove}, 32'd1); adv();
    settle(); chk("rstseq_count_one", {30'd0, obuf_count}, 32'd1);     adv();
    rst = 1'b1;
    settle(); chk("rstseq_remove_in_rst", {31'd0, pifo_remove}, 32'd0); adv();
    settle();
    chk("rstseq_m_valid", {31'd0, m_valid}, 32'd0);
    chk("rstseq_count", {30'd0, obuf_count}, 32'd0);
    chk("rstseq_m_meta", {24'd0, m_meta}, 32'd0);
    chk("rstseq_remove", {31'd0, pifo_remove}, 32'd0);
    adv();
    rst = 1'b0;
    settle(); chk("rstseq_remove_after", {31'd0, pifo_remove}, 32'd1); adv();

    // Continuous stream with m_ready high: occupancy stays at most 1 and
    // removes come every HOLDOFF+1 cycles.
    m_ready = 1'b1;
    nrem = 0;
    for (int i = 0; i < 30; i++) begin
      pifo_rank = 8'(i + 8'h40); pifo_meta = 8'($urandom_range(255));
      settle();
      chk("stream_occupancy_le1", {31'd0, obuf_count <= 2'd1}, 32'd1);
      if (pifo_remove) nrem++;
      adv();
    end
    chk("stream_remove_count", nrem, 10);

`ifdef PIFO_DEQ_STATS_EN
    rst = 1'b1;
    settle(); adv(); settle(); adv();
    rst = 1'b0;
    chk("stats_deq_reset", deq_count, 32'd0);
    chk("stats_stall_reset", stall_count, 32'd0);
    nrem = 0; guard = 0;
    while (nrem < 5 && guard < 100) begin
      settle();
      if (pifo_remove) nrem++;
      adv();
      guard++;
    end
    chk("stats_five_removes", nrem, 5);
    deq_en = 1'b0; m_ready = 1'b0;
    repeat (7) begin settle(); adv(); end
    m_ready = 1'b1;
    settle(); adv();
    m_ready = 1'b0;
    settle();
    chk("stats_deq_count", deq_count, 32'd5);
    chk("stats_stall_count", stall_count, 32'd7);
    adv();
`else
    guard = 0;
`endif

    chk("scoreboard_drained_or_pending", {31'd0, sb_q.size() <= 2}, 32'd1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
